fpu_rr_sched: RTL and testbench

FPU_RR_SCHED -- requirements
Module: fpu_rr_sched

---
 rtl/fpu_sched_pkg.sv | 14 +
 rtl/rr_arb2.sv | 20 ++
 rtl/fpu_rr_sched.sv | 112 +++++++++++
 tb/tb_fpu_rr_sched.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_sched_pkg.sv
// Shared widths and FSM state encoding for the two-requester FPU scheduler.
package fpu_sched_pkg;

  localparam int FPU_W = 16;
  localparam int OP_W  = 4;
  localparam int NREQ  = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie, the requester not granted last wins.
module rr_arb2
  import fpu_sched_pkg::*;
(
  input  logic [NREQ-1:0] valid_i,
  input  logic            last_i,
  output logic [NREQ-1:0] grant_o
);

  always_comb begin
    grant_o = '0;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
      default: grant_o = '0;
    endcase
  end

endmodule

// File: rtl/fpu_rr_sched.sv
// Shares one FPU between two requesters: round-robin accept, hold operands for
// FPU_LAT cycles, then present the result to the owner until it is taken.
module fpu_rr_sched
  import fpu_sched_pkg::*;
#(
  parameter int unsigned FPU_LAT = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0][FPU_W-1:0] req_a,
  input  logic [NREQ-1:0][FPU_W-1:0] req_b,
  input  logic [NREQ-1:0][OP_W-1:0]  req_op,
  output logic [NREQ-1:0]            rsp_valid,
  input  logic [NREQ-1:0]            rsp_ready,
  output logic [FPU_W-1:0]           rsp_y,
  output logic [FPU_W-1:0]           fpu_a,
  output logic [FPU_W-1:0]           fpu_b,
  output logic [OP_W-1:0]            fpu_sel,
  input  logic [FPU_W-1:0]           fpu_y,
  output logic                       busy
);

  localparam logic [1:0] LAT_M1 = 2'(FPU_LAT - 1);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [FPU_W-1:0] a_q, a_d;
  logic [FPU_W-1:0] b_q, b_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [FPU_W-1:0] res_q, res_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]  grant;

  rr_arb2 u_arb (
    .valid_i (req_valid),
    .last_i  (last_q),
    .grant_o (grant)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    rsp_valid = '0;
    case (state_q)
      IDLE: begin
        // grant is already qualified by req_valid, so any grant is an accept
        req_ready = grant;
        if (|grant) begin
          owner_d = grant[1];
          last_d  = grant[1];
          a_d     = req_a[grant[1]];
          b_d     = req_b[grant[1]];
          op_d    = req_op[grant[1]];
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == LAT_M1) begin
          res_d   = fpu_y;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_y   = res_q;
  assign fpu_a   = a_q;
  assign fpu_b   = b_q;
  assign fpu_sel = op_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fpu_rr_sched.sv
// Bench for fpu_rr_sched: vector table, corner sequences, and a randomized
// run against a timeline-based reference model (FPU_LAT=1 and FPU_LAT=4 DUTs).
module tb_fpu_rr_sched;
  import fpu_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       rv, rr, sv, sr;
  logic [1:0][15:0] ra, rb;
  logic [1:0][3:0]  ro;
  logic [15:0]      ry, fa, fb, fy;
  logic [3:0]       fs;
  logic             bz;

  logic [1:0]       rv4, rr4, sv4, sr4;
  logic [1:0][15:0] ra4, rb4;
  logic [1:0][3:0]  ro4;
  logic [15:0]      ry4, fa4, fb4, fy4;
  logic [3:0]       fs4;
  logic             bz4;

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] fpu_f(logic [15:0] a, logic [15:0] b, logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a ^ b;
      default: return a & b;
    endcase
  endfunction

  assign fy = fpu_f(fa, fb, fs);

  logic [15:0] p4 [3] = '{default: 16'h0};
  always @(posedge clk) begin
    p4[0] <= fpu_f(fa4, fb4, fs4);
    p4[1] <= p4[0];
    p4[2] <= p4[1];
  end
  assign fy4 = p4[2];

  fpu_rr_sched #(.FPU_LAT(1)) dut (
    .clock(clk), .reset(rst), .req_valid(rv), .req_ready(rr), .req_a(ra), .req_b(rb),
    .req_op(ro), .rsp_valid(sv), .rsp_ready(sr), .rsp_y(ry), .fpu_a(fa), .fpu_b(fb),
    .fpu_sel(fs), .fpu_y(fy), .busy(bz)
  );

  fpu_rr_sched #(.FPU_LAT(4)) dut4 (
    .clock(clk), .reset(rst), .req_valid(rv4), .req_ready(rr4), .req_a(ra4), .req_b(rb4),
    .req_op(ro4), .rsp_valid(sv4), .rsp_ready(sr4), .rsp_y(ry4), .fpu_a(fa4), .fpu_b(fb4),
    .fpu_sel(fs4), .fpu_y(fy4), .busy(bz4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rv = '0; sr = '0; rv4 = '0; sr4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {rr, sv, ry, fa, fb, fs, bz}, '0);
    chk("rst_out4", {rr4, sv4, ry4, fa4, fb4, fs4, bz4}, '0);
    rst = 1'b0;
  endtask

  typedef struct {
    int unsigned idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] y;
  } vec_t;

  vec_t vt [6];

  task automatic run_vec(input int k);
    int unsigned i;
    logic [1:0] oh;
    i  = vt[k].idx;
    oh = 2'b01 << i;
    @(posedge clk); #1;
    rv = '0; sr = '0;
    rv[i] = 1'b1; ra[i] = vt[k].a; rb[i] = vt[k].b; ro[i] = vt[k].op;
    @(negedge clk);
    chk($sformatf("vec%0d_rdy", k), rr, oh);
    @(posedge clk); #1;
    rv = '0; ra[i] = ~vt[k].a; rb[i] = ~vt[k].b; ro[i] = ~vt[k].op;
    @(negedge clk);
    chk($sformatf("vec%0d_issue_v", k), sv, 2'b00);
    chk($sformatf("vec%0d_fpu_ops", k), {fa, fb, fs}, {vt[k].a, vt[k].b, vt[k].op});
    @(posedge clk); #1;
    sr = ~oh;
    @(negedge clk);
    chk($sformatf("vec%0d_rsp_v", k), sv, oh);
    chk($sformatf("vec%0d_rsp_y", k), ry, vt[k].y);
    @(posedge clk); #1;
    sr = oh;
    @(negedge clk);
    chk($sformatf("vec%0d_nonowner_ign", k), {sv, ry}, {oh, vt[k].y});
    @(posedge clk); #1;
    sr = '0;
    @(negedge clk);
    chk($sformatf("vec%0d_done", k), {sv, bz}, 3'b000);
  endtask

  // Reference model: an accept at cycle c owes a response from cycle c+1+LAT
  // until the owner's rsp_ready; no new accept while a response is owed.
  task automatic run_eng(input int mode, input int ncyc);
    logic        last_m = 1'b1;
    bit          inflt  = 1'b0;
    int unsigned own    = 0;
    int unsigned gi     = 0;
    logic [15:0] yexp   = '0;
    int          due    = 0;
    int          got    = 0;
    logic [1:0]  acc    = '0;
    logic [1:0]  er, evv;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) rv[i] = 1'b0;
        if (!rv[i] && (mode == 1 || $urandom_range(0, 2) == 0)) begin
          rv[i] = 1'b1;
          ra[i] = 16'($urandom);
          rb[i] = 16'($urandom);
          ro[i] = 4'($urandom_range(0, 1));
        end
      end
      acc = '0;
      sr  = (mode == 1) ? 2'b11 : 2'($urandom);
      @(negedge clk);
      er = '0;
      if (!inflt && rv != 2'b00) begin
        gi = (rv == 2'b11) ? (last_m ? 0 : 1) : (rv[0] ? 0 : 1);
        er = 2'b01 << gi;
      end
      evv = (inflt && c >= due) ? (2'b01 << own) : 2'b00;
      chk($sformatf("rnd_rdy_c%0d", c), rr, er);
      chk($sformatf("rnd_rspv_c%0d", c), sv, evv);
      chk($sformatf("rnd_busy_c%0d", c), bz, inflt);
      if (evv != 2'b00) chk($sformatf("rnd_y_c%0d", c), ry, yexp);
      if (mode == 1 && (sv & sr) != 2'b00) begin
        chk($sformatf("alt_owner_%0d", got), sv, (got % 2 == 0) ? 2'b01 : 2'b10);
        got++;
      end
      if (er != 2'b00) begin
        inflt  = 1'b1;
        own    = gi;
        yexp   = fpu_f(ra[gi], rb[gi], ro[gi]);
        due    = c + 2;
        last_m = gi[0];
        acc[gi] = 1'b1;
      end else if (evv != 2'b00 && sr[own]) begin
        inflt = 1'b0;
      end
      if (mode == 1 && got == 10) break;
    end
    if (mode == 1) chk("alt_count", got, 10);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rv = '0; sr = '0; ra = '0; rb = '0; ro = '0;
    rv4 = '0; sr4 = '0; ra4 = '0; rb4 = '0; ro4 = '0;

    vt[0] = '{0, 16'h3C00, 16'h4000, 4'd0, 16'h7C00};
    vt[1] = '{1, 16'hFFFF, 16'h0001, 4'd0, 16'h0000};
    vt[2] = '{0, 16'hAAAA, 16'h5555, 4'd1, 16'hFFFF};
    vt[3] = '{1, 16'h1234, 16'h1234, 4'd1, 16'h0000};
    vt[4] = '{1, 16'h0F00, 16'h00F0, 4'd0, 16'h0FF0};
    vt[5] = '{0, 16'h8000, 16'h8000, 4'd0, 16'h0000};

    do_reset();
    @(negedge clk);
    chk("idle_no_req", {rr, sv, bz}, 5'b00000);

    for (int k = 0; k < 6; k++) run_vec(k);

    // tie from reset: requester 0 first, then requester 1
    do_reset();
    @(posedge clk); #1;
    rv = 2'b11; sr = 2'b11;
    ra[0] = 16'h00FF; rb[0] = 16'h0F0F; ro[0] = 4'd1;
    ra[1] = 16'h0001; rb[1] = 16'h0002; ro[1] = 4'd0;
    @(negedge clk); chk("tie_rdy0", rr, 2'b01);
    @(posedge clk); #1; rv[0] = 1'b0;
    @(negedge clk); chk("tie_wait", rr, 2'b00);
    @(posedge clk); #1;
    @(negedge clk); chk("tie_rsp0", {sv, ry}, {2'b01, 16'h0FF0});
    @(posedge clk); #1;
    @(negedge clk); chk("tie_rdy1", rr, 2'b10);
    @(posedge clk); #1; rv[1] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); chk("tie_rsp1", {sv, ry}, {2'b10, 16'h0003});
    @(posedge clk); #1; sr = '0;

    // backpressure with a pending request on the other port
    @(posedge clk); #1;
    rv = 2'b01; ra[0] = 16'h1234; rb[0] = 16'h1111; ro[0] = 4'd0; sr = '0;
    @(negedge clk); chk("bp_rdy0", rr, 2'b01);
    @(posedge clk); #1;
    rv = 2'b10; ra[1] = 16'h0005; rb[1] = 16'h0003; ro[1] = 4'd1; ra[0] = '0;
    @(negedge clk); chk("bp_issue_rdy", rr, 2'b00);
    @(posedge clk); #1; sr = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {sv, ry, bz, rr}, {2'b01, 16'h2345, 1'b1, 2'b00});
      @(posedge clk); #1;
    end
    sr = 2'b01;
    @(negedge clk); chk("bp_take", {sv, rr}, {2'b01, 2'b00});
    @(posedge clk); #1; sr = '0;
    @(negedge clk); chk("bp_next_acc", rr, 2'b10);
    @(posedge clk); #1; rv = '0;
    @(posedge clk); #1;
    @(negedge clk); chk("bp_rsp1", {sv, ry}, {2'b10, 16'h0006});
    sr = 2'b10;
    @(posedge clk); #1; sr = '0;

    // reset pulse while in ISSUE
    @(posedge clk); #1;
    rv = 2'b01; ra[0] = 16'h0007; rb[0] = 16'h0008; ro[0] = 4'd0;
    @(negedge clk); chk("rmid_rdy", rr, 2'b01);
    @(posedge clk); #1; rv = '0;
    #2 rst = 1'b1;
    #1 chk("rmid_out", {rr, sv, ry, fa, fb, fs, bz}, '0);
    @(negedge clk); rst = 1'b0; sr = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk($sformatf("rmid_norsp%0d", k), sv, 2'b00);
    end
    @(posedge clk); #1;
    rv = 2'b11; sr = '0;
    ra[0] = 16'h0001; rb[0] = 16'h0001; ra[1] = 16'h0002; rb[1] = 16'h0002;
    ro[0] = 4'd0; ro[1] = 4'd0;
    @(negedge clk); chk("rmid_tie", rr, 2'b01);
    @(posedge clk); #1; rv = '0; sr = 2'b11;
    repeat (4) @(posedge clk);
    #1 sr = '0;

    // FPU_LAT=4 instance
    @(posedge clk); #1;
    rv4 = 2'b01; ra4[0] = 16'h0101; rb4[0] = 16'h0202; ro4[0] = 4'd0;
    @(negedge clk); chk("l4_rdy", rr4, 2'b01);
    @(posedge clk); #1;
    rv4 = '0; ra4[0] = 16'hDEAD; rb4[0] = 16'hBEEF; ro4[0] = 4'd1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("l4_issue%0d", k), {fa4, fb4, fs4, sv4, bz4},
          {16'h0101, 16'h0202, 4'd0, 2'b00, 1'b1});
      @(posedge clk); #1;
    end
    @(negedge clk); chk("l4_rsp", {sv4, ry4}, {2'b01, 16'h0303});
    sr4 = 2'b01;
    @(posedge clk); #1; sr4 = '0;
    @(negedge clk); chk("l4_retain", {bz4, sv4, fa4, fb4}, {1'b0, 2'b00, 16'h0101, 16'h0202});

    do_reset();
    run_eng(1, 60);
    do_reset();
    run_eng(0, 400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
